// File: rtl/keypad_code_sender.sv
// Keypad-side driver for the access-code lock: buffers typed codes, strobes them
// to the lock one at a time, reports grant/deny, and locks out after repeated denies.
module keypad_code_sender #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned RESP_TIMEOUT   = 8,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 20
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            key_valid,
  input  logic [3:0]                      key_code,
  output logic                            key_ready,
  output logic [3:0]                      access_code,
  output logic                            validate_code,
  input  logic                            open_access_door,
  output logic                            grant,
  output logic                            deny,
  output logic                            lockout,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic [1:0]                      state_out
);

  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned RTW = $clog2(RESP_TIMEOUT + 1);
  localparam int unsigned FW  = $clog2(MAX_FAILS + 1);
  localparam int unsigned LTW = $clog2(LOCKOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    WAIT = 2'b10,
    LOCK = 2'b11
  } state_t;

  state_t          state;
  logic [3:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [RTW-1:0]  resp_timer;
  logic [FW-1:0]   fail_cnt;
  logic [LTW-1:0]  lock_timer;

  logic full;
  logic empty;
  logic resp_expired;
  logic push;
  logic pop;
  logic flush;

  assign full         = (count == CW'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign key_ready    = !full && !lockout;
  assign resp_expired = (resp_timer == RTW'(RESP_TIMEOUT - 1));
  assign pop          = (state == IDLE) && !empty;
  // Final deny of a streak: the FIFO is flushed on the edge that enters LOCK.
  assign flush        = (state == WAIT) && !open_access_door && resp_expired &&
                        (fail_cnt == FW'(MAX_FAILS - 1));
  assign push         = key_valid && key_ready && !flush;

  assign fifo_count = count;
  assign state_out  = state;

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= key_code;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer: present code, await door response, track failures and lockout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      access_code   <= '0;
      validate_code <= 1'b0;
      grant         <= 1'b0;
      deny          <= 1'b0;
      lockout       <= 1'b0;
      resp_timer    <= '0;
      fail_cnt      <= '0;
      lock_timer    <= '0;
    end else begin
      validate_code <= 1'b0;
      grant         <= 1'b0;
      deny          <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            access_code   <= mem[rd_ptr];
            validate_code <= 1'b1;
            state         <= SEND;
          end
        end
        SEND: begin
          resp_timer <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          if (open_access_door) begin
            grant    <= 1'b1;
            fail_cnt <= '0;
            state    <= IDLE;
          end else if (resp_expired) begin
            deny     <= 1'b1;
            fail_cnt <= fail_cnt + FW'(1);
            if (fail_cnt == FW'(MAX_FAILS - 1)) begin
              lockout    <= 1'b1;
              lock_timer <= '0;
              state      <= LOCK;
            end else begin
              state <= IDLE;
            end
          end else begin
            resp_timer <= resp_timer + RTW'(1);
          end
        end
        LOCK: begin
          if (lock_timer == LTW'(LOCKOUT_CYCLES - 1)) begin
            lockout  <= 1'b0;
            fail_cnt <= '0;
            state    <= IDLE;
          end else begin
            lock_timer <= lock_timer + LTW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_code_sender.sv
// Scoreboarded bench for keypad_code_sender: expected codes are queued on push
// and checked against access_code whenever validate_code strobes.
module tb_keypad_code_sender;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned TIMEOUT  = 8;
  localparam int unsigned LOCK_CYC = 20;

  logic       clk;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [3:0] access_code;
  logic       validate_code;
  logic       open_access_door;
  logic       grant;
  logic       deny;
  logic       lockout;
  logic [2:0] fifo_count;
  logic [1:0] state_out;

  int checks;
  int failures;
  logic [3:0] exp_q[$];

  keypad_code_sender #(
    .FIFO_DEPTH(DEPTH), .RESP_TIMEOUT(TIMEOUT), .MAX_FAILS(3), .LOCKOUT_CYCLES(LOCK_CYC)
  ) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .access_code(access_code), .validate_code(validate_code),
    .open_access_door(open_access_door), .grant(grant), .deny(deny),
    .lockout(lockout), .fifo_count(fifo_count), .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every strobe must carry the oldest queued code.
  task automatic monitor();
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && validate_code === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_strobe: unexpected strobe with access_code=%0d", access_code);
        end else begin
          if (access_code !== exp_q[0]) begin
            failures++;
            $display("FAIL sb_code: access_code=%0d expected=%0d", access_code, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        checks++;
        if (prev_v) begin
          failures++;
          $display("FAIL strobe_width: validate_code high %0d consecutive cycles, expected 1", 2);
        end
      end
      if (grant === 1'b1 || deny === 1'b1) begin
        checks++;
        if (grant === 1'b1 && deny === 1'b1) begin
          failures++;
          $display("FAIL grant_deny: grant=%b deny=%b, expected not both", grant, deny);
        end
      end
      prev_v = validate_code;
    end
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    key_valid        = 1'b0;
    key_code         = '0;
    open_access_door = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic push(input logic [3:0] code, input logic exp_acc);
    checks++;
    if (key_ready !== exp_acc) begin
      failures++;
      $display("FAIL push_ready: key_ready=%b expected=%b (code %0d)", key_ready, exp_acc, code);
    end
    key_valid = 1'b1;
    key_code  = code;
    if (exp_acc) exp_q.push_back(code);
    tick();
    key_valid = 1'b0;
  endtask

  // Lock model: opens the door open_delay cycles after the strobe (-1 = never).
  task automatic run_txn(input int open_delay, output int res, output int lat);
    int since;
    since = -1;
    res   = 0;
    for (int n = 0; n < 60 && res == 0; n++) begin
      if (validate_code === 1'b1) since = 0;
      if (open_delay >= 0 && since == open_delay) open_access_door = 1'b1;
      tick();
      if (since >= 0) since++;
      if (grant === 1'b1) res = 1;
      else if (deny === 1'b1) res = 2;
    end
    open_access_door = 1'b0;
    lat = since;
    checks++;
    if (res == 0) begin
      failures++;
      $display("FAIL txn_timeout: no grant or deny within %0d cycles", 60);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; key_valid = 1'b0; key_code = '0; open_access_door = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    checks += 8;
    if (access_code !== 4'd0)   begin failures++; $display("FAIL rst_code: got %0d want 0", access_code); end
    if (validate_code !== 1'b0) begin failures++; $display("FAIL rst_validate: got %b want 0", validate_code); end
    if (grant !== 1'b0)         begin failures++; $display("FAIL rst_grant: got %b want 0", grant); end
    if (deny !== 1'b0)          begin failures++; $display("FAIL rst_deny: got %b want 0", deny); end
    if (lockout !== 1'b0)       begin failures++; $display("FAIL rst_lockout: got %b want 0", lockout); end
    if (key_ready !== 1'b1)     begin failures++; $display("FAIL rst_ready: got %b want 1", key_ready); end
    if (state_out !== 2'b00)    begin failures++; $display("FAIL rst_state: got %b want 00", state_out); end
    if (fifo_count !== 3'd0)    begin failures++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
  endtask

  task automatic test_grant();
    int res, lat;
    push(4'd9, 1'b1);
    run_txn(2, res, lat);
    checks += 2;
    if (res != 1) begin failures++; $display("FAIL grant_result: got %0d want 1 (grant)", res); end
    if (lat != 3) begin failures++; $display("FAIL grant_latency: got %0d want 3 cycles after strobe", lat); end
    tick();
    checks += 2;
    if (grant !== 1'b0)      begin failures++; $display("FAIL grant_pulse: grant=%b want 0 next cycle", grant); end
    if (state_out !== 2'b00) begin failures++; $display("FAIL grant_state: got %b want 00", state_out); end
  endtask

  task automatic test_deny_timeout();
    int res, lat;
    push(4'd0, 1'b1);
    run_txn(-1, res, lat);
    checks += 3;
    if (res != 2)           begin failures++; $display("FAIL deny_result: got %0d want 2 (deny)", res); end
    if (lat != TIMEOUT + 1) begin failures++; $display("FAIL deny_latency: got %0d want %0d", lat, TIMEOUT + 1); end
    if (state_out !== 2'b00) begin failures++; $display("FAIL deny_state: got %b want 00", state_out); end
  endtask

  task automatic test_lockout();
    int res, lat, n;
    do_reset();
    push(4'd0, 1'b1);
    push(4'd1, 1'b1);
    push(4'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      run_txn(-1, res, lat);
      checks++;
      if (res != 2) begin failures++; $display("FAIL lock_deny%0d: got %0d want 2", i, res); end
    end
    checks += 3;
    if (lockout !== 1'b1)    begin failures++; $display("FAIL lock_flag: got %b want 1", lockout); end
    if (state_out !== 2'b11) begin failures++; $display("FAIL lock_state: got %b want 11", state_out); end
    if (fifo_count !== 3'd0) begin failures++; $display("FAIL lock_count: got %0d want 0", fifo_count); end
    push(4'd5, 1'b0);
    n = 1;
    checks++;
    if (fifo_count !== 3'd0) begin failures++; $display("FAIL lock_drop: fifo_count=%0d want 0", fifo_count); end
    while (lockout === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks += 3;
    if (n != LOCK_CYC)       begin failures++; $display("FAIL lock_len: lockout lasted %0d want %0d", n, LOCK_CYC); end
    if (state_out !== 2'b00) begin failures++; $display("FAIL unlock_state: got %b want 00", state_out); end
    if (key_ready !== 1'b1)  begin failures++; $display("FAIL unlock_ready: got %b want 1", key_ready); end
    push(4'd9, 1'b1);
    run_txn(2, res, lat);
    checks++;
    if (res != 1) begin failures++; $display("FAIL unlock_grant: got %0d want 1", res); end
  endtask

  task automatic test_fifo_full();
    logic       exp_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] exp_cnt [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    open_access_door = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push(4'(i + 1), exp_rdy[i]);
      checks++;
      if (fifo_count !== exp_cnt[i]) begin
        failures++;
        $display("FAIL full_count%0d: fifo_count=%0d want %0d", i, fifo_count, exp_cnt[i]);
      end
    end
    checks += 3;
    if (access_code !== 4'd1) begin failures++; $display("FAIL full_head: access_code=%0d want 1", access_code); end
    if (key_ready !== 1'b0)   begin failures++; $display("FAIL full_ready: key_ready=%b want 0", key_ready); end
    if (state_out !== 2'b10)  begin failures++; $display("FAIL full_state: got %b want 10", state_out); end
  endtask

  task automatic test_reset_mid();
    int n;
    int pulses;
    do_reset();
    push(4'd7, 1'b1);
    push(4'd8, 1'b1);
    push(4'd3, 1'b1);
    n = 0;
    while (state_out !== 2'b10 && n < 10) begin
      tick();
      n++;
    end
    checks += 2;
    if (state_out !== 2'b10) begin failures++; $display("FAIL mid_wait: state=%b want 10", state_out); end
    if (fifo_count !== 3'd2) begin failures++; $display("FAIL mid_count: fifo_count=%0d want 2", fifo_count); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    checks += 5;
    if (state_out !== 2'b00)  begin failures++; $display("FAIL mid_rst_state: got %b want 00", state_out); end
    if (fifo_count !== 3'd0)  begin failures++; $display("FAIL mid_rst_count: got %0d want 0", fifo_count); end
    if (access_code !== 4'd0) begin failures++; $display("FAIL mid_rst_code: got %0d want 0", access_code); end
    if (grant !== 1'b0)       begin failures++; $display("FAIL mid_rst_grant: got %b want 0", grant); end
    if (deny !== 1'b0)        begin failures++; $display("FAIL mid_rst_deny: got %b want 0", deny); end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (grant === 1'b1 || deny === 1'b1 || validate_code === 1'b1) pulses++;
    end
    checks += 2;
    if (pulses != 0)          begin failures++; $display("FAIL mid_quiet: %0d pulses seen, want 0", pulses); end
    if (state_out !== 2'b00)  begin failures++; $display("FAIL mid_idle: got %b want 00", state_out); end
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    reset            = 1'b1;
    key_valid        = 1'b0;
    key_code         = '0;
    open_access_door = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_grant();
    test_deny_timeout();
    test_lockout();
    test_fifo_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
